// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared constants and helpers for the integer register file
package reg_file_sb_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] RA = 5'd1;
  localparam logic [4:0] SP = 5'd2;
  localparam logic [4:0] GP = 5'd3;
  localparam logic [4:0] TP = 5'd4;
  localparam logic [4:0] T0 = 5'd5;
  localparam logic [4:0] T1 = 5'd6;
  localparam logic [4:0] T2 = 5'd7;
  localparam logic [4:0] S0 = 5'd8;
  localparam logic [4:0] S1 = 5'd9;

  // Guards against addresses beyond REGS when the address space is not fully populated.
  function automatic logic addr_in_range(input logic [31:0] addr, input int regs);
    return addr < 32'(regs);
  endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// rtl/reg_file_sb_scoreboard.sv - per-register busy bits for loads awaiting write-back
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int REGS = NUM_REGS,
  parameter int AW   = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] rd_addr,
  input  logic          busy_set,
  input  logic [AW-1:0] busy_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  logic [REGS-1:0] busy;

  // A new load to the same register supersedes the result being written back, so set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < REGS; i++) begin
        if (busy_set && busy_addr == AW'(i)) begin
          busy[i] <= 1'b1;
        end else if (we && rd_addr == AW'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  assign rs1_busy = addr_in_range(32'(rs1_addr), REGS) ? busy[rs1_addr] : 1'b0;
  assign rs2_busy = addr_in_range(32'(rs2_addr), REGS) ? busy[rs2_addr] : 1'b0;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - integer register file with write-back bypass and busy scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int N      = XLEN,
  parameter int REGS   = NUM_REGS,
  parameter int AW     = REG_AW,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [N-1:0]  rs1_data,
  output logic [N-1:0]  rs2_data,
  input  logic          we,
  input  logic [AW-1:0] rd_addr,
  input  logic [N-1:0]  rd_data,
  input  logic          busy_set,
  input  logic [AW-1:0] busy_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  logic [N-1:0] regs [REGS];
  logic         wr_ok;
  logic         rs1_ok, rs2_ok;
  logic         fwd1, fwd2;
  logic         sb_busy1, sb_busy2;

  assign wr_ok = we && (rd_addr != '0) && addr_in_range(32'(rd_addr), REGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_ok = (rs1_addr != '0) && addr_in_range(32'(rs1_addr), REGS);
  assign rs2_ok = (rs2_addr != '0) && addr_in_range(32'(rs2_addr), REGS);

  // Forwarding is held off during reset so the read ports show the cleared state.
  assign fwd1 = BYPASS && rst_n && we && (rd_addr == rs1_addr);
  assign fwd2 = BYPASS && rst_n && we && (rd_addr == rs2_addr);

  assign rs1_data = !rs1_ok ? '0 : (fwd1 ? rd_data : regs[rs1_addr]);
  assign rs2_data = !rs2_ok ? '0 : (fwd2 ? rd_data : regs[rs2_addr]);

  reg_scoreboard #(
    .REGS (REGS),
    .AW   (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .rd_addr   (rd_addr),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (sb_busy1),
    .rs2_busy  (sb_busy2)
  );

  // A register whose result is being forwarded this cycle no longer needs a stall.
  assign rs1_busy = sb_busy1 && !(BYPASS && we && (rd_addr == rs1_addr));
  assign rs2_busy = sb_busy2 && !(BYPASS && we && (rd_addr == rs2_addr));

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb, bypass and non-bypass builds
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, busy_addr;
  logic        we, busy_set;
  logic [31:0] rd_data;
  logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
  logic        b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] mregs [32];
  bit          mbusy [32];

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .we(we), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy_set(busy_set), .busy_addr(busy_addr),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy)
  );

  reg_file_sb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1_data), .rs2_data(n_rs2_data), .we(we), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy_set(busy_set), .busy_addr(busy_addr),
    .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy)
  );

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == REG_ZERO) return 32'h0;
    if (byp && rst_n && we && rd_addr == a) return rd_data;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    return mbusy[a] && !(byp && we && rd_addr == a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 32'h0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (we && rd_addr != REG_ZERO) mregs[rd_addr] = rd_data;
      if (we) mbusy[rd_addr] = 1'b0;
      if (busy_set && busy_addr != REG_ZERO) mbusy[busy_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0; busy_set = 1'b0; rd_addr = '0; busy_addr = '0; rd_data = '0;
  endtask

  task automatic test_reset();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; rd_addr = 5'(i); rd_data = 32'hA5A5_0000 + 32'(i);
      busy_set = 1'b1; busy_addr = 5'(i);
      tick();
    end
    idle();
    rs1_addr = 5'd31; rs2_addr = 5'd17;
    #1;
    total++;
    if (b_rs1_data !== exp_data(5'd31, 1) || b_rs2_data !== exp_data(5'd17, 1)) begin
      $display("FAIL reset_prefill got=%h/%h exp=%h/%h", b_rs1_data, b_rs2_data,
               exp_data(5'd31, 1), exp_data(5'd17, 1));
      bad++;
    end
    total++;
    if (b_rs1_busy !== 1'b1) begin
      $display("FAIL reset_prefill_busy got=%b exp=1", b_rs1_busy);
      bad++;
    end
    #1;
    rst_n = 1'b0;
    model_clear();
    we = 1'b1; rd_data = 32'hFFFF_FFFF; busy_set = 1'b1; busy_addr = 5'd4;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); rd_addr = 5'(i);
      #1;
      total++;
      if (b_rs1_data !== 32'h0 || b_rs2_data !== 32'h0 || n_rs1_data !== 32'h0 || n_rs2_data !== 32'h0) begin
        $display("FAIL reset_data addr=%0d got=%h/%h/%h/%h exp=0", i, b_rs1_data, b_rs2_data,
                 n_rs1_data, n_rs2_data);
        bad++;
      end
      total++;
      if ({b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy} !== 4'b0) begin
        $display("FAIL reset_busy addr=%0d got=%b%b%b%b exp=0000", i, b_rs1_busy, b_rs2_busy,
                 n_rs1_busy, n_rs2_busy);
        bad++;
      end
    end
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rs1_addr = 5'd31; rs2_addr = 5'd4;
    #1;
    total++;
    if (b_rs1_data !== 32'h0 || b_rs2_busy !== 1'b0) begin
      $display("FAIL reset_after got=%h/%b exp=0/0", b_rs1_data, b_rs2_busy);
      bad++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_x0();
    we = 1'b1; rd_addr = REG_ZERO; rd_data = 32'hDEAD_BEEF;
    rs1_addr = REG_ZERO; rs2_addr = REG_ZERO;
    #1;
    total++;
    if (b_rs1_data !== 32'h0 || b_rs2_data !== 32'h0) begin
      $display("FAIL x0_same got=%h/%h exp=0", b_rs1_data, b_rs2_data);
      bad++;
    end
    tick();
    idle();
    #1;
    total++;
    if (b_rs1_data !== 32'h0 || n_rs1_data !== 32'h0) begin
      $display("FAIL x0_next got=%h/%h exp=0", b_rs1_data, n_rs1_data);
      bad++;
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; rd_addr = T0; rd_data = 32'h1234_5678;
    tick();
    idle();
    rs1_addr = T0; rs2_addr = T0;
    #1;
    total++;
    if (b_rs1_data !== 32'h1234_5678 || b_rs2_data !== 32'h1234_5678 || n_rs1_data !== 32'h1234_5678) begin
      $display("FAIL write_read got=%h/%h/%h exp=12345678", b_rs1_data, b_rs2_data, n_rs1_data);
      bad++;
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; rd_addr = T2; rd_data = 32'h11;
    tick();
    rd_data = 32'h22; rs1_addr = S0; rs2_addr = T2;
    #1;
    total++;
    if (b_rs2_data !== 32'h22) begin
      $display("FAIL bypass_fwd got=%h exp=22", b_rs2_data);
      bad++;
    end
    total++;
    if (n_rs2_data !== 32'h11) begin
      $display("FAIL bypass_off got=%h exp=11", n_rs2_data);
      bad++;
    end
    tick();
    idle();
    #1;
    total++;
    if (b_rs2_data !== 32'h22 || n_rs2_data !== 32'h22) begin
      $display("FAIL bypass_after got=%h/%h exp=22", b_rs2_data, n_rs2_data);
      bad++;
    end
  endtask

  task automatic test_scoreboard();
    busy_set = 1'b1; busy_addr = S1;
    tick();
    idle();
    rs1_addr = S1; rs2_addr = S0;
    #1;
    total++;
    if (b_rs1_busy !== 1'b1 || n_rs1_busy !== 1'b1 || b_rs2_busy !== 1'b0) begin
      $display("FAIL sb_set got=%b/%b/%b exp=1/1/0", b_rs1_busy, n_rs1_busy, b_rs2_busy);
      bad++;
    end
    we = 1'b1; rd_addr = S1; rd_data = 32'h0BAD_F00D;
    #1;
    total++;
    if (b_rs1_busy !== 1'b0 || n_rs1_busy !== 1'b1) begin
      $display("FAIL sb_wb_same got=%b/%b exp=0/1", b_rs1_busy, n_rs1_busy);
      bad++;
    end
    tick();
    idle();
    #1;
    total++;
    if (b_rs1_busy !== 1'b0 || n_rs1_busy !== 1'b0) begin
      $display("FAIL sb_clear got=%b/%b exp=0/0", b_rs1_busy, n_rs1_busy);
      bad++;
    end
  endtask

  task automatic test_collision();
    busy_set = 1'b1; busy_addr = GP;
    tick();
    we = 1'b1; rd_addr = GP; rd_data = 32'hCAFE_0003;
    tick();
    idle();
    rs1_addr = GP;
    #1;
    total++;
    if (b_rs1_busy !== 1'b1 || n_rs1_busy !== 1'b1) begin
      $display("FAIL collision_busy got=%b/%b exp=1/1", b_rs1_busy, n_rs1_busy);
      bad++;
    end
    total++;
    if (b_rs1_data !== 32'hCAFE_0003) begin
      $display("FAIL collision_data got=%h exp=cafe0003", b_rs1_data);
      bad++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      we        = ($urandom_range(0, 3) != 0);
      rd_addr   = 5'($urandom_range(0, 31));
      rd_data   = $urandom();
      busy_set  = ($urandom_range(0, 2) == 0);
      busy_addr = 5'($urandom_range(0, 31));
      rs1_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr  = ($urandom_range(0, 4) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
      #1;
      total++;
      if (b_rs1_data !== exp_data(rs1_addr, 1) || b_rs2_data !== exp_data(rs2_addr, 1)) begin
        $display("FAIL rand_byp_data cyc=%0d got=%h/%h exp=%h/%h", c, b_rs1_data, b_rs2_data,
                 exp_data(rs1_addr, 1), exp_data(rs2_addr, 1));
        bad++;
      end
      total++;
      if (n_rs1_data !== exp_data(rs1_addr, 0) || n_rs2_data !== exp_data(rs2_addr, 0)) begin
        $display("FAIL rand_nb_data cyc=%0d got=%h/%h exp=%h/%h", c, n_rs1_data, n_rs2_data,
                 exp_data(rs1_addr, 0), exp_data(rs2_addr, 0));
        bad++;
      end
      total++;
      if (b_rs1_busy !== exp_busy(rs1_addr, 1) || b_rs2_busy !== exp_busy(rs2_addr, 1) ||
          n_rs1_busy !== exp_busy(rs1_addr, 0) || n_rs2_busy !== exp_busy(rs2_addr, 0)) begin
        $display("FAIL rand_busy cyc=%0d got=%b%b%b%b exp=%b%b%b%b", c, b_rs1_busy, b_rs2_busy,
                 n_rs1_busy, n_rs2_busy, exp_busy(rs1_addr, 1), exp_busy(rs2_addr, 1),
                 exp_busy(rs1_addr, 0), exp_busy(rs2_addr, 0));
        bad++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    idle();
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    test_reset();
    test_x0();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
